ram_access_scheduler: RTL and testbench
=======================================

# ram_access_scheduler

Arbitration and sequencing front-end for the car-park record RAM (128 x 40-bit, separate write and read ports with single-cycle enable pulses and Busy flags). Two record producers share the RAM write port under round-robin arbitration: the entry-gate logger (port 0) and the exit-gate logger (port 1). Written records go to a circular log with an auto-incrementing write pointer. One query client reads arbitrary addresses through a request/acknowledge/valid handshake. The block sits between the gate/display logic and the RAM instance and is the only driver of the RAM enables.

## Interface
- ADDR_W, 7, RAM address width
- DATA_W, 40, record width
- DEPTH, 128, log entries (= 2**ADDR_W)
- RD_LATENCY, 1, Clock cycles from RAM RdEnable pulse to RdData valid (1..3)

- Clock  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately
- Req0Valid / Req1Valid  in  1  producer has a record to log
- Req0Data / Req1Data  in  DATA_W  record payload
- Req0Ready / Req1Ready  out  1  record accepted on this edge when Valid is also high
- RdReq  in  1  query request
- RdAddr  in  ADDR_W  query address, sampled on acceptance
- RdAck  out  1  query accepted this cycle
- RdValid  out  1  one-cycle pulse when RdOut is valid
- RdOut  out  DATA_W  query result; holds until the next RdValid
- RamWrEnable  out  1  single-cycle write pulse to the RAM
- RamWrData  out  DATA_W  RAM write data
- RamAddressWR  out  ADDR_W  RAM write address
- RamBusyWR  in  1  RAM write port busy
- RamRdEnable  out  1  single-cycle read pulse to the RAM
- RamAddressRD  out  ADDR_W  RAM read address
- RamRdData  in  DATA_W  RAM read data
- RamBusyRD  in  1  RAM read port busy
- WrPtr  out  ADDR_W  next log slot
- Count  out  ADDR_W+1  valid entries, saturates at DEPTH
- Full  out  1  Count == DEPTH
- Overflow  out  1  sticky flag: an entry was overwritten; cleared only by reset

## Operation
- Reset values:
  - All outputs are 0.
  - Internal last-grant register = 1, so port 0 wins the first tie.
  - Both FSMs start in their IDLE state.
- Write FSM states:
  - W_IDLE: grant = the only valid port; if both are valid, the port not granted last. ReqNReady = W_IDLE && !RamBusyWR && grant==N. On Valid&&Ready: register data into RamWrData, register WrPtr into RamAddressWR, update last-grant, go to W_ISSUE.
  - W_ISSUE: RamWrEnable=1 for exactly one cycle. WrPtr <= WrPtr+1, wrapping 127->0. Count increments; at DEPTH it stays and Overflow sets. Return to W_IDLE.
- Read FSM states:
  - R_IDLE: RdAck = RdReq && !RamBusyRD. On ack, capture RdAddr into RamAddressRD and go to R_ISSUE.
  - R_ISSUE: RamRdEnable=1 for one cycle, then go to R_WAIT.
  - R_WAIT: count RD_LATENCY cycles, then RdOut <= RamRdData and RdValid=1 for one cycle. Return to R_IDLE.
- Write and read FSMs run independently and concurrently.
- No forwarding: a read of a slot written in the same cycle returns whatever the RAM returns.
- RamAddressWR, RamAddressRD and RamWrData hold their last value between accesses.
- Busy only gates acceptance. An access already in W_ISSUE or R_ISSUE is issued even if Busy rises.

## Timing
- Write: accepted at edge k; RamWrEnable high for the cycle after edge k; WrPtr and Count update at edge k+1.
- Write throughput: at most one write per 2 cycles. Ready is low while in W_ISSUE.
- Read: RdAck at edge k; RamRdEnable during the cycle after k; RdValid at edge k+2+RD_LATENCY.
- Read throughput: one query per 3+RD_LATENCY cycles.
- Ready and RdAck are combinational from Valid/RdReq, Busy and state. All other outputs are registered.
- Reset asserted mid-operation: all outputs drop to 0 asynchronously. A pending pulse is cancelled, an accepted but unissued record is lost, and any read in flight never returns RdValid.

## Test plan
- Reset, then Req0Valid alone with data 0x00000000AA -> Req0Ready=1 for 1 cycle; next cycle RamWrEnable=1, RamAddressWR=0, RamWrData=0x00000000AA; WrPtr=1, Count=1.
- Both producers held valid for 6 accepts -> grants alternate 0,1,0,1,0,1; writes go to addresses 0..5 in order, one every 2 cycles.
- 130 writes -> WrPtr wraps 127->0 and ends at 2; Count stays 128; Full=1; Overflow sets on write 129.
- RamBusyWR=1 with Req0Valid=1 -> Ready=0 and no RamWrEnable; drop Busy -> accepted on the next edge.
- RdReq with RdAddr=0x05 after the writes, RD_LATENCY=1 -> RamRdEnable with RamAddressRD=0x05; RdValid 3 cycles after RdAck; RdOut equals the record written to slot 5. Concurrent writes do not disturb it.
- Reset asserted during R_WAIT and W_ISSUE -> all outputs 0 immediately; no RdValid afterwards; WrPtr=0 and Count=0 after release.

Source files
------------

// File: rtl/ram_access_scheduler.sv
// ram_access_scheduler
//   Front-end for the car-park record RAM. Two record producers share the
//   RAM write port under round-robin arbitration and fill a circular log.
//   One query client reads arbitrary slots through a req/ack/valid handshake.
//   This block is the only driver of the RAM enables.
//
//   Write FSM
//   state   | meaning
//   W_IDLE  | waiting for a producer; Ready offered to the granted port
//   W_ISSUE | RamWrEnable pulse; pointer and count advance on exit
//
//   Read FSM
//   state   | meaning
//   R_IDLE  | waiting for a query; RdAck offered when the read port is free
//   R_ISSUE | RamRdEnable pulse
//   R_WAIT  | latency down-counter runs; RdOut captured at terminal count
//
// Ports
//   Clock, Reset             system clock, async active-low reset
//   Req0*/Req1*              producer valid/data in, ready out
//   RdReq/RdAddr/RdAck       query request, address, acceptance
//   RdValid/RdOut            query result pulse and held data
//   RamWr*/RamAddressWR      RAM write port (enable, data, address, busy)
//   RamRd*/RamAddressRD      RAM read port (enable, data, address, busy)
//   WrPtr/Count/Full         log status
//   Overflow                 sticky: a log entry has been overwritten
module ram_access_scheduler #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 40,
    parameter int DEPTH      = 128,
    parameter int RD_LATENCY = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0Valid,
    input  logic [DATA_W-1:0] Req0Data,
    output logic              Req0Ready,
    input  logic              Req1Valid,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              Req1Ready,
    input  logic              RdReq,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic              RdAck,
    output logic              RdValid,
    output logic [DATA_W-1:0] RdOut,
    output logic              RamWrEnable,
    output logic [DATA_W-1:0] RamWrData,
    output logic [ADDR_W-1:0] RamAddressWR,
    input  logic              RamBusyWR,
    output logic              RamRdEnable,
    output logic [ADDR_W-1:0] RamAddressRD,
    input  logic [DATA_W-1:0] RamRdData,
    input  logic              RamBusyRD,
    output logic [ADDR_W-1:0] WrPtr,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0]      LAT_LOAD   = 2'(RD_LATENCY);

    typedef enum logic {W_IDLE, W_ISSUE} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} r_state_t;

    w_state_t   w_state, w_state_nxt;
    r_state_t   r_state, r_state_nxt;
    logic       last_grant;
    logic       grant;
    logic       grant_any;
    logic       wr_accept;
    logic [1:0] lat_cnt;
    logic       lat_done;

    // grant: 1 selects port 1. On a tie the port not served last wins.
    always_comb begin
        grant_any = Req0Valid | Req1Valid;
        if (Req0Valid && Req1Valid) begin
            grant = ~last_grant;
        end else begin
            grant = Req1Valid;
        end
    end

    // Write FSM next state / handshake. Ready is gated by Reset so that all
    // outputs read 0 while reset is held, even with producers still valid.
    always_comb begin
        w_state_nxt = w_state;
        Req0Ready   = 1'b0;
        Req1Ready   = 1'b0;
        wr_accept   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (Reset && !RamBusyWR && grant_any) begin
                    Req0Ready   = ~grant;
                    Req1Ready   = grant;
                    wr_accept   = 1'b1;
                    w_state_nxt = W_ISSUE;
                end
            end
            W_ISSUE: w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            w_state      <= W_IDLE;
            last_grant   <= 1'b1;
            RamWrEnable  <= 1'b0;
            RamWrData    <= '0;
            RamAddressWR <= '0;
            WrPtr        <= '0;
            Count        <= '0;
            Full         <= 1'b0;
            Overflow     <= 1'b0;
        end else begin
            w_state     <= w_state_nxt;
            RamWrEnable <= wr_accept;
            if (wr_accept) begin
                RamWrData    <= grant ? Req1Data : Req0Data;
                RamAddressWR <= WrPtr;
                last_grant   <= grant;
            end
            if (w_state == W_ISSUE) begin
                // DEPTH is a power of two, so the pointer wraps naturally
                WrPtr <= WrPtr + 1'b1;
                if (Count == FULL_COUNT) begin
                    Overflow <= 1'b1;
                end else begin
                    Count <= Count + 1'b1;
                    Full  <= ((Count + 1'b1) == FULL_COUNT);
                end
            end
        end
    end

    assign lat_done = (lat_cnt == 2'd0);

    always_comb begin
        r_state_nxt = r_state;
        RdAck       = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (Reset && RdReq && !RamBusyRD) begin
                    RdAck       = 1'b1;
                    r_state_nxt = R_ISSUE;
                end
            end
            R_ISSUE: r_state_nxt = R_WAIT;
            R_WAIT:  if (lat_done) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state      <= R_IDLE;
            RamRdEnable  <= 1'b0;
            RamAddressRD <= '0;
            lat_cnt      <= 2'd0;
            RdValid      <= 1'b0;
            RdOut        <= '0;
        end else begin
            r_state     <= r_state_nxt;
            RamRdEnable <= RdAck;
            RdValid     <= 1'b0;
            if (RdAck) begin
                RamAddressRD <= RdAddr;
            end
            // Counter is loaded with the full latency on entry to R_WAIT and
            // the capture happens one edge after it reaches zero, which gives
            // the RAM RD_LATENCY cycles after the enable is sampled.
            if (r_state == R_ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (r_state == R_WAIT) begin
                if (lat_done) begin
                    RdOut   <= RamRdData;
                    RdValid <= 1'b1;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Testbench for ram_access_scheduler: directed stimulus, a behavioural
// RAM, and a transaction-level model checked against the DUT every cycle.
module tb_ram_access_scheduler;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 40;
    localparam int DEPTH  = 128;
    localparam int RD_LAT = 1;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              Req0Valid = 1'b0, Req1Valid = 1'b0;
    logic [DATA_W-1:0] Req0Data = '0, Req1Data = '0;
    logic              Req0Ready, Req1Ready;
    logic              RdReq = 1'b0;
    logic [ADDR_W-1:0] RdAddr = '0;
    logic              RdAck, RdValid;
    logic [DATA_W-1:0] RdOut;
    logic              RamWrEnable;
    logic [DATA_W-1:0] RamWrData;
    logic [ADDR_W-1:0] RamAddressWR;
    logic              RamBusyWR = 1'b0;
    logic              RamRdEnable;
    logic [ADDR_W-1:0] RamAddressRD;
    logic [DATA_W-1:0] RamRdData = '0;
    logic              RamBusyRD = 1'b0;
    logic [ADDR_W-1:0] WrPtr;
    logic [ADDR_W:0]   Count;
    logic              Full, Overflow;

    ram_access_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LATENCY(RD_LAT)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
        .Req1Valid(Req1Valid), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
        .RdReq(RdReq), .RdAddr(RdAddr), .RdAck(RdAck),
        .RdValid(RdValid), .RdOut(RdOut),
        .RamWrEnable(RamWrEnable), .RamWrData(RamWrData),
        .RamAddressWR(RamAddressWR), .RamBusyWR(RamBusyWR),
        .RamRdEnable(RamRdEnable), .RamAddressRD(RamAddressRD),
        .RamRdData(RamRdData), .RamBusyRD(RamBusyRD),
        .WrPtr(WrPtr), .Count(Count), .Full(Full), .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int pcnt   = 0;

    always @(posedge Clock) pcnt <= pcnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural RAM, one cycle read latency
    logic [DATA_W-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge Clock) begin
        if (RamWrEnable) mem[RamAddressWR] <= RamWrData;
        if (RamRdEnable) RamRdData <= mem[RamAddressRD];
    end

    // ---------------- transaction-level model ----------------
    logic [DATA_W-1:0] m_log [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) m_log[i] = '0;
    bit                m_last   = 1'b1;   // 1: port 1 served most recently
    bit                m_wissue = 1'b0;   // a write pulse is on the RAM port
    int                m_waddr  = 0;
    logic [DATA_W-1:0] m_wdata  = '0;
    int                m_ptr    = 0;
    int                m_count  = 0;
    bit                m_ovf    = 1'b0;
    int                m_rphase = 0;      // 0 idle, else edges since query accepted
    int                m_raddr  = 0;
    logic [DATA_W-1:0] m_rsnap  = '0;
    logic [DATA_W-1:0] m_rout   = '0;
    bit                m_rvalid = 1'b0;

    function automatic int pick(input logic v0, input logic v1, input bit last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge Clock or negedge Reset) begin : model
        int g;
        bit rd_go;
        if (!Reset) begin
            m_last = 1'b1; m_wissue = 1'b0; m_waddr = 0; m_wdata = '0;
            m_ptr = 0; m_count = 0; m_ovf = 1'b0;
            m_rphase = 0; m_raddr = 0; m_rout = '0; m_rvalid = 1'b0;
        end else begin
            // read side: RAM samples the address one edge after acceptance
            rd_go    = (m_rphase == 0) && RdReq && !RamBusyRD;
            m_rvalid = 1'b0;
            if (m_rphase == 1) m_rsnap = m_log[m_raddr];
            if (m_rphase == RD_LAT + 2) begin
                m_rvalid = 1'b1;
                m_rout   = m_rsnap;
                m_rphase = 0;
            end else if (m_rphase > 0) begin
                m_rphase++;
            end else if (rd_go) begin
                m_rphase = 1;
                m_raddr  = int'(RdAddr);
            end
            // write side
            if (m_wissue) begin
                m_log[m_waddr] = m_wdata;
                m_ptr = (m_ptr + 1) % DEPTH;
                if (m_count == DEPTH) m_ovf = 1'b1;
                else m_count++;
                m_wissue = 1'b0;
            end else begin
                g = pick(Req0Valid, Req1Valid, m_last);
                if (g >= 0 && !RamBusyWR) begin
                    m_wissue = 1'b1;
                    m_waddr  = m_ptr;
                    m_wdata  = (g == 1) ? Req1Data : Req0Data;
                    m_last   = (g == 1);
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge Clock) begin : cmp
        int g;
        g = pick(Req0Valid, Req1Valid, m_last);
        chk("req0_ready", Req0Ready, Reset && !m_wissue && !RamBusyWR && g == 0);
        chk("req1_ready", Req1Ready, Reset && !m_wissue && !RamBusyWR && g == 1);
        chk("rd_ack", RdAck, Reset && m_rphase == 0 && RdReq && !RamBusyRD);
        chk("ram_wr_en", RamWrEnable, m_wissue);
        chk("ram_wr_addr", RamAddressWR, m_waddr);
        chk("ram_wr_data", RamWrData, m_wdata);
        chk("wr_ptr", WrPtr, m_ptr);
        chk("count", Count, m_count);
        chk("full", Full, m_count == DEPTH);
        chk("overflow", Overflow, m_ovf);
        chk("ram_rd_en", RamRdEnable, m_rphase == 1);
        chk("ram_rd_addr", RamAddressRD, m_raddr);
        chk("rd_valid", RdValid, m_rvalid);
        chk("rd_out", RdOut, m_rout);
    end

    // Write issue log for ordering/spacing checks
    int wr_addrs[$];
    int wr_cycs[$];
    int grants[$];
    always @(negedge Clock) if (Reset && RamWrEnable) begin
        wr_addrs.push_back(int'(RamAddressWR));
        wr_cycs.push_back(pcnt);
    end

    // ---------------- stimulus ----------------
    int seq0, seq1;

    function automatic logic [DATA_W-1:0] mk(input int p, input int s);
        return {(p == 1) ? 8'hB1 : 8'h5A, 32'(s)};
    endfunction

    task automatic do_reset();
        @(posedge Clock); #2;
        Reset = 1'b0;
        Req0Valid = 1'b0; Req1Valid = 1'b0; RdReq = 1'b0;
        RamBusyWR = 1'b0; RamBusyRD = 1'b0;
        repeat (2) @(negedge Clock);
        #2 Reset = 1'b1;
    endtask

    // Holds the selected producers valid until n records are accepted
    task automatic run_writes(input int n, input bit use0, input bit use1);
        int got = 0;
        int cyc = 0;
        bit f0, f1;
        seq0 = 0; seq1 = 0;
        @(posedge Clock); #1;
        Req0Data = mk(0, seq0); Req1Data = mk(1, seq1);
        Req0Valid = use0; Req1Valid = use1;
        while (got < n && cyc < 4 * n + 20) begin
            @(negedge Clock);
            f0 = Req0Valid && Req0Ready;
            f1 = Req1Valid && Req1Ready;
            if (f0) grants.push_back(0);
            if (f1) grants.push_back(1);
            @(posedge Clock); #1;
            if (f0) begin seq0++; Req0Data = mk(0, seq0); end
            if (f1) begin seq1++; Req1Data = mk(1, seq1); end
            got += int'(f0) + int'(f1);
            cyc++;
            if (got >= n) begin Req0Valid = 1'b0; Req1Valid = 1'b0; end
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        chk("wr_accepts", got, n);
    endtask

    task automatic read_slot5();
        int a_cyc = 0;
        int v_cyc = 0;
        bit seen = 1'b0;
        @(posedge Clock); #1;
        RamBusyRD = 1'b1; RdReq = 1'b1; RdAddr = 7'h05;
        @(negedge Clock);
        chk("rd_ack_busy", RdAck, 0);
        @(posedge Clock); #1;
        RamBusyRD = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clock);
            if (RdAck) begin seen = 1'b1; a_cyc = pcnt; end
        end
        chk("rd_ack_seen", seen, 1);
        @(posedge Clock); #1;
        RdReq = 1'b0;
        @(negedge Clock);
        chk("rd_en_pulse", RamRdEnable, 1);
        chk("rd_addr_lit", RamAddressRD, 7'h05);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge Clock);
            if (RdValid) begin seen = 1'b1; v_cyc = pcnt; end
        end
        chk("rd_valid_seen", seen, 1);
        // ack is sampled in the cycle ending at the accept edge, RdValid in the
        // cycle after the edge RD_LAT+2 later
        chk("rd_latency", v_cyc - a_cyc, RD_LAT + 3);
        chk("rd_data_slot5", RdOut, 40'h5A_0000_0005);
        @(negedge Clock);
        chk("rd_out_hold", RdOut, 40'h5A_0000_0005);
    endtask

    initial begin
        int n_after;
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_wren", RamWrEnable, 0);
        chk("rst_count", Count, 0);
        chk("rst_rdout", RdOut, 0);
        #2 Reset = 1'b1;

        // single write from port 0
        @(posedge Clock); #1;
        Req0Valid = 1'b1; Req0Data = 40'h00_0000_00AA;
        @(negedge Clock);
        chk("t1_ready", Req0Ready, 1);
        @(posedge Clock); #1;
        Req0Valid = 1'b0;
        @(negedge Clock);
        chk("t1_wren", RamWrEnable, 1);
        chk("t1_addr", RamAddressWR, 0);
        chk("t1_data", RamWrData, 40'h00_0000_00AA);
        @(negedge Clock);
        chk("t1_wrptr", WrPtr, 1);
        chk("t1_count", Count, 1);
        chk("t1_wren_off", RamWrEnable, 0);

        // both producers contending
        do_reset();
        grants.delete(); wr_addrs.delete(); wr_cycs.delete();
        run_writes(6, 1'b1, 1'b1);
        repeat (2) @(negedge Clock);
        chk("t2_ngrants", grants.size(), 6);
        chk("t2_nwrites", wr_addrs.size(), 6);
        for (int i = 0; i < 6 && i < grants.size() && i < wr_addrs.size(); i++) begin
            chk("t2_grant", grants[i], i % 2);
            chk("t2_addr", wr_addrs[i], i);
            if (i > 0) chk("t2_spacing", wr_cycs[i] - wr_cycs[i-1], 2);
        end

        // fill, wrap and overflow
        do_reset();
        run_writes(128, 1'b1, 1'b0);
        repeat (2) @(negedge Clock);
        chk("t3_ptr128", WrPtr, 0);
        chk("t3_count128", Count, 128);
        chk("t3_full128", Full, 1);
        chk("t3_ovf128", Overflow, 0);
        run_writes(2, 1'b1, 1'b0);
        repeat (2) @(negedge Clock);
        chk("t3_ptr130", WrPtr, 2);
        chk("t3_count130", Count, 128);
        chk("t3_full130", Full, 1);
        chk("t3_ovf130", Overflow, 1);

        // query slot 5 while port 1 writes slots 2 and 3
        fork
            run_writes(2, 1'b0, 1'b1);
            read_slot5();
        join
        repeat (2) @(negedge Clock);
        chk("t4_ptr", WrPtr, 4);

        // write port busy
        @(posedge Clock); #1;
        RamBusyWR = 1'b1; Req0Valid = 1'b1; Req0Data = 40'h00_0000_0077;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("t5_ready_busy", Req0Ready, 0);
            chk("t5_wren_busy", RamWrEnable, 0);
        end
        @(posedge Clock); #1;
        RamBusyWR = 1'b0;
        @(negedge Clock);
        chk("t5_ready_free", Req0Ready, 1);
        @(posedge Clock); #1;
        Req0Valid = 1'b0;
        @(negedge Clock);
        chk("t5_wren", RamWrEnable, 1);
        chk("t5_addr", RamAddressWR, 4);
        chk("t5_data", RamWrData, 40'h00_0000_0077);
        repeat (2) @(negedge Clock);

        // reset while a read waits and a write is issuing
        @(posedge Clock); #1;
        RdReq = 1'b1; RdAddr = 7'h07;
        @(negedge Clock);
        chk("t6_ack", RdAck, 1);
        @(posedge Clock); #1;
        RdReq = 1'b0; Req0Valid = 1'b1; Req0Data = 40'h00_0000_0099;
        @(negedge Clock);
        chk("t6_ready", Req0Ready, 1);
        @(posedge Clock); #1;
        Req0Valid = 1'b0;
        chk("t6_wren_pre", RamWrEnable, 1);
        #2 Reset = 1'b0;
        #1;
        chk("t6_wren_rst", RamWrEnable, 0);
        chk("t6_rdout_rst", RdOut, 0);
        chk("t6_wrdata_rst", RamWrData, 0);
        chk("t6_rdaddr_rst", RamAddressRD, 0);
        chk("t6_ovf_rst", Overflow, 0);
        chk("t6_full_rst", Full, 0);
        @(negedge Clock); #2;
        Reset = 1'b1;
        n_after = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (RdValid) n_after++;
        end
        chk("t6_no_rdvalid", n_after, 0);
        chk("t6_ptr", WrPtr, 0);
        chk("t6_count", Count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
